// File: rtl/tensor_core_mkn.sv
// tensor_core_mkn: multi-cycle M x K by K x N multiply-accumulate engine, one K-slice per cycle.
// Operands latch on acceptance; results are clamped or wrapped on the final MAC edge, then held in DONE.
module tensor_core_mkn #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int SIZE_M     = 4,
  parameter int SIZE_K     = 4,
  parameter int SIZE_N     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   opcode,
  input  logic signed [DATA_WIDTH-1:0] matrix_a [SIZE_M][SIZE_K],
  input  logic signed [DATA_WIDTH-1:0] matrix_b [SIZE_K][SIZE_N],
  input  logic signed [ACC_WIDTH-1:0]  matrix_c [SIZE_M][SIZE_N],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  matrix_d [SIZE_M][SIZE_N],
  output logic                         sat_flag,
  output logic                         op_err
);

  localparam int PW  = 2 * DATA_WIDTH + 1;
  localparam int BW  = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;
  localparam int AW  = BW + $clog2(SIZE_K) + 1;
  localparam int KCW = (SIZE_K > 1) ? $clog2(SIZE_K) : 1;
  localparam logic [KCW-1:0] K_LAST = KCW'(SIZE_K - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [KCW-1:0]               k_q, k_d;
  logic                         sat_en_q, sat_en_d;
  logic                         uns_en_q, uns_en_d;
  logic signed [DATA_WIDTH-1:0] a_q [SIZE_M][SIZE_K];
  logic signed [DATA_WIDTH-1:0] a_d [SIZE_M][SIZE_K];
  logic signed [DATA_WIDTH-1:0] b_q [SIZE_K][SIZE_N];
  logic signed [DATA_WIDTH-1:0] b_d [SIZE_K][SIZE_N];
  logic signed [AW-1:0]         acc_q [SIZE_M][SIZE_N];
  logic signed [AW-1:0]         acc_d [SIZE_M][SIZE_N];
  logic signed [AW-1:0]         acc_next_s [SIZE_M][SIZE_N];
  logic [ACC_WIDTH:0]           fin_s [SIZE_M][SIZE_N];
  logic signed [ACC_WIDTH-1:0]  d_q [SIZE_M][SIZE_N];
  logic signed [ACC_WIDTH-1:0]  d_d [SIZE_M][SIZE_N];
  logic                         sat_flag_q, sat_flag_d;
  logic                         op_err_q, op_err_d;

  // One product term, extended by mode; the true product always fits in 2*DATA_WIDTH+1 bits.
  function automatic logic signed [AW-1:0] mac_term(input logic signed [DATA_WIDTH-1:0] a,
                                                    input logic signed [DATA_WIDTH-1:0] b,
                                                    input logic uns);
    logic signed [2*DATA_WIDTH+1:0] ea;
    logic signed [2*DATA_WIDTH+1:0] eb;
    logic signed [2*DATA_WIDTH+1:0] p;
    if (uns) begin
      ea = {{(DATA_WIDTH+2){1'b0}}, a};
      eb = {{(DATA_WIDTH+2){1'b0}}, b};
    end else begin
      ea = {{(DATA_WIDTH+2){a[DATA_WIDTH-1]}}, a};
      eb = {{(DATA_WIDTH+2){b[DATA_WIDTH-1]}}, b};
    end
    p = ea * eb;
    return AW'(p);
  endfunction

  // Returns {clamped, value}: the value fits when all bits above the result sign agree.
  function automatic logic [ACC_WIDTH:0] finalise(input logic signed [AW-1:0] v, input logic sat);
    logic [AW-ACC_WIDTH:0] hi;
    hi = v[AW-1:ACC_WIDTH-1];
    if (!sat) begin
      return {1'b0, v[ACC_WIDTH-1:0]};
    end else if (hi == {(AW-ACC_WIDTH+1){v[AW-1]}}) begin
      return {1'b0, v[ACC_WIDTH-1:0]};
    end else if (v[AW-1]) begin
      return {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  endfunction

  // Current K-slice accumulation and its finalised view.
  always_comb begin
    for (int i = 0; i < SIZE_M; i++) begin
      for (int j = 0; j < SIZE_N; j++) begin
        acc_next_s[i][j] = acc_q[i][j] + mac_term(a_q[i][k_q], b_q[k_q][j], uns_en_q);
        fin_s[i][j]      = finalise(acc_next_s[i][j], sat_en_q);
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sat_en_d   = sat_en_q;
    uns_en_d   = uns_en_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    d_d        = d_q;
    sat_flag_d = sat_flag_q;
    op_err_d   = op_err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = matrix_a;
          b_d      = matrix_b;
          sat_en_d = opcode[1];
          uns_en_d = opcode[2];
          k_d      = {KCW{1'b0}};
          for (int i = 0; i < SIZE_M; i++) begin
            for (int j = 0; j < SIZE_N; j++) begin
              if (opcode[0]) begin
                acc_d[i][j] = AW'(matrix_c[i][j]);
              end else begin
                acc_d[i][j] = {AW{1'b0}};
              end
            end
          end
          sat_flag_d = 1'b0;
          if (opcode[7:3] != 5'd0) begin
            // Illegal opcodes are still consumed so the source never stalls on them.
            state_d  = ST_DONE;
            op_err_d = 1'b1;
            for (int i = 0; i < SIZE_M; i++) begin
              for (int j = 0; j < SIZE_N; j++) begin
                d_d[i][j] = {ACC_WIDTH{1'b0}};
              end
            end
          end else begin
            state_d  = ST_MAC;
            op_err_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_next_s;
        if (k_q == K_LAST) begin
          state_d    = ST_DONE;
          sat_flag_d = 1'b0;
          for (int i = 0; i < SIZE_M; i++) begin
            for (int j = 0; j < SIZE_N; j++) begin
              d_d[i][j]  = fin_s[i][j][ACC_WIDTH-1:0];
              sat_flag_d = sat_flag_d | fin_s[i][j][ACC_WIDTH];
            end
          end
        end else begin
          k_d = k_q + KCW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= {KCW{1'b0}};
      sat_en_q   <= 1'b0;
      uns_en_q   <= 1'b0;
      sat_flag_q <= 1'b0;
      op_err_q   <= 1'b0;
      for (int i = 0; i < SIZE_M; i++) begin
        for (int k = 0; k < SIZE_K; k++) begin
          a_q[i][k] <= {DATA_WIDTH{1'b0}};
        end
      end
      for (int k = 0; k < SIZE_K; k++) begin
        for (int j = 0; j < SIZE_N; j++) begin
          b_q[k][j] <= {DATA_WIDTH{1'b0}};
        end
      end
      for (int i = 0; i < SIZE_M; i++) begin
        for (int j = 0; j < SIZE_N; j++) begin
          acc_q[i][j] <= {AW{1'b0}};
          d_q[i][j]   <= {ACC_WIDTH{1'b0}};
        end
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sat_en_q   <= sat_en_d;
      uns_en_q   <= uns_en_d;
      sat_flag_q <= sat_flag_d;
      op_err_q   <= op_err_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      d_q        <= d_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign matrix_d  = d_q;
  assign sat_flag  = sat_flag_q;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_tensor_core_mkn.sv
// Directed self-checking bench: default 4x4x4 instance plus a 2x3x5 instance for the
// non-square shape and reset-mid-MAC scenario.
module tb_tensor_core_mkn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n;

  logic               in_valid1, in_ready1, out_valid1, out_ready1, sat1, err1;
  logic [7:0]         op1;
  logic signed [15:0] a1 [4][4];
  logic signed [15:0] b1 [4][4];
  logic signed [31:0] c1 [4][4];
  logic signed [31:0] d1 [4][4];

  logic               in_valid2, in_ready2, out_valid2, out_ready2, sat2, err2;
  logic [7:0]         op2;
  logic signed [15:0] a2 [2][3];
  logic signed [15:0] b2 [3][5];
  logic signed [31:0] c2 [2][5];
  logic signed [31:0] d2 [2][5];

  int tests = 0;
  int fails = 0;
  int exp2 [2][5] = '{'{16, 14, 12, 10, 8}, '{98, 105, 112, 119, 126}};

  tensor_core_mkn u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .opcode(op1),
    .matrix_a(a1), .matrix_b(b1), .matrix_c(c1), .out_valid(out_valid1), .out_ready(out_ready1),
    .matrix_d(d1), .sat_flag(sat1), .op_err(err1)
  );

  tensor_core_mkn #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIZE_M(2), .SIZE_K(3), .SIZE_N(5)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_ready(in_ready2), .opcode(op2),
    .matrix_a(a2), .matrix_b(b2), .matrix_c(c2), .out_valid(out_valid2), .out_ready(out_ready2),
    .matrix_d(d2), .sat_flag(sat2), .op_err(err2)
  );

  // Accept one operand set on instance 1; lat = edges from accept edge to the edge that sees out_valid.
  task automatic run1(input logic [7:0] op, output int lat);
    @(negedge clk);
    op1 = op;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid1 === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic run2(input logic [7:0] op, output int lat);
    @(negedge clk);
    op2 = op;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid2 === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic release1();
    @(negedge clk);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
  endtask

  task automatic release2();
    @(negedge clk);
    out_ready2 = 1'b1;
    @(posedge clk);
    #1 out_ready2 = 1'b0;
  endtask

  task automatic fill1(input logic signed [15:0] av, input logic signed [15:0] bv,
                       input logic signed [31:0] cv);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a1[i][j] = av;
        b1[i][j] = bv;
        c1[i][j] = cv;
      end
    end
  endtask

  task automatic load_identity(input int bscale);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a1[i][j] = (i == j) ? 16'sd1 : 16'sd0;
        b1[i][j] = 16'(bscale * (i * 4 + j));
        c1[i][j] = 32'sd1;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; rst2_n = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; op1 = 8'h00;
    in_valid2 = 1'b0; out_ready2 = 1'b0; op2 = 8'h00;
    fill1(16'sd0, 16'sd0, 32'sd0);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 5; j++) c2[i][j] = 32'sd0;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) a2[i][k] = 16'sd0;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 5; j++) b2[k][j] = 16'sd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || sat1 !== 1'b0 || err1 !== 1'b0) begin
      $display("FAIL reset_ctrl: got rdy=%b vld=%b sat=%b err=%b expected 1 0 0 0",
               in_ready1, out_valid1, sat1, err1);
      fails++;
    end
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (d1[i][j] !== 32'sd0) bad++;
    tests++;
    if (bad != 0) begin
      $display("FAIL reset_d: got %0d nonzero elements expected 0", bad);
      fails++;
    end
    tests++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      $display("FAIL reset_ctrl2: got rdy=%b vld=%b expected 1 0", in_ready2, out_valid2);
      fails++;
    end
  endtask

  task automatic test_identity();
    int lat, bad;
    load_identity(1);
    for (int pass = 0; pass < 2; pass++) begin
      run1((pass == 0) ? 8'h01 : 8'h03, lat);
      tests++;
      if (lat !== 5) begin
        $display("FAIL identity_latency: got %0d expected 5", lat);
        fails++;
      end
      bad = 0;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
        if (d1[i][j] !== 32'(i * 4 + j + 1)) begin
          if (bad == 0) $display("FAIL identity_d[%0d][%0d]: got %0d expected %0d", i, j, d1[i][j], i * 4 + j + 1);
          bad++;
        end
      tests++;
      if (bad != 0) fails++;
      tests++;
      if (sat1 !== 1'b0 || err1 !== 1'b0) begin
        $display("FAIL identity_flags: got sat=%b err=%b expected 0 0", sat1, err1);
        fails++;
      end
      release1();
      tests++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
        $display("FAIL identity_handshake: got vld=%b rdy=%b expected 0 1", out_valid1, in_ready1);
        fails++;
      end
    end
  endtask

  task automatic test_accumulate_off();
    int lat, bad;
    load_identity(1);
    run1(8'h00, lat);
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
      if (d1[i][j] !== 32'(i * 4 + j)) begin
        if (bad == 0) $display("FAIL accoff_d[%0d][%0d]: got %0d expected %0d", i, j, d1[i][j], i * 4 + j);
        bad++;
      end
    tests++;
    if (bad != 0 || lat !== 5) begin
      if (lat !== 5) $display("FAIL accoff_latency: got %0d expected 5", lat);
      fails++;
    end
    release1();
  endtask

  task automatic test_saturation();
    int lat, bad;
    logic signed [31:0] expv [3] = '{32'sh7FFFFFFF, 32'sh7FFC0003, 32'sh80000000};
    logic               exps [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]         ops  [3] = '{8'h03, 8'h01, 8'h03};
    for (int t = 0; t < 3; t++) begin
      if (t < 2) fill1(16'sh7FFF, 16'sh7FFF, 32'sh7FFFFFFF);
      else       fill1(16'sh8000, 16'sh7FFF, 32'sh80000000);
      run1(ops[t], lat);
      bad = 0;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
        if (d1[i][j] !== expv[t]) bad++;
      tests++;
      if (bad != 0) begin
        $display("FAIL sat_case%0d_d: got %h expected %h", t, d1[0][0], expv[t]);
        fails++;
      end
      tests++;
      if (sat1 !== exps[t]) begin
        $display("FAIL sat_case%0d_flag: got %b expected %b", t, sat1, exps[t]);
        fails++;
      end
      release1();
    end
  endtask

  task automatic test_unsigned();
    int lat, bad;
    logic signed [31:0] expv [2] = '{32'shFFF80004, 32'sh00000004};
    logic [7:0]         ops  [2] = '{8'h04, 8'h00};
    fill1(16'shFFFF, 16'shFFFF, 32'sd0);
    for (int t = 0; t < 2; t++) begin
      run1(ops[t], lat);
      bad = 0;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
        if (d1[i][j] !== expv[t]) bad++;
      tests++;
      if (bad != 0 || sat1 !== 1'b0) begin
        $display("FAIL unsigned_case%0d: got d=%h sat=%b expected d=%h sat=0", t, d1[0][0], sat1, expv[t]);
        fails++;
      end
      release1();
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad, unstable;
    load_identity(1);
    run1(8'h01, lat);
    load_identity(2);
    op1 = 8'h00;
    in_valid1 = 1'b1;
    unstable = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || d1[1][2] !== 32'sd7 || d1[3][3] !== 32'sd16) unstable++;
    end
    tests++;
    if (unstable != 0) begin
      $display("FAIL backpressure_hold: got %0d unstable cycles (vld=%b rdy=%b d12=%0d) expected 0",
               unstable, out_valid1, in_ready1, d1[1][2]);
      fails++;
    end
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
    tests++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      $display("FAIL backpressure_release: got vld=%b rdy=%b expected 0 1", out_valid1, in_ready1);
      fails++;
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid1 === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
    tests++;
    if (lat !== 5) begin
      $display("FAIL second_set_latency: got %0d expected 5", lat);
      fails++;
    end
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
      if (d1[i][j] !== 32'(2 * (i * 4 + j))) bad++;
    tests++;
    if (bad != 0) begin
      $display("FAIL second_set_d: got d12=%0d expected %0d", d1[1][2], 12);
      fails++;
    end
    release1();
  endtask

  task automatic test_illegal_opcode();
    int lat, bad;
    load_identity(1);
    run1(8'h80, lat);
    tests++;
    if (lat !== 1) begin
      $display("FAIL illegal_latency: got %0d expected 1", lat);
      fails++;
    end
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (d1[i][j] !== 32'sd0) bad++;
    tests++;
    if (bad != 0 || err1 !== 1'b1 || sat1 !== 1'b0) begin
      $display("FAIL illegal_result: got nonzero=%0d err=%b sat=%b expected 0 1 0", bad, err1, sat1);
      fails++;
    end
    release1();
    run1(8'h01, lat);
    tests++;
    if (err1 !== 1'b0 || d1[2][3] !== 32'sd12) begin
      $display("FAIL illegal_recover: got err=%b d23=%0d expected 0 12", err1, d1[2][3]);
      fails++;
    end
    release1();
  endtask

  task automatic check_shape2(input string name);
    int lat, bad;
    run2(8'h01, lat);
    tests++;
    if (lat !== 4) begin
      $display("FAIL %s_latency: got %0d expected 4", name, lat);
      fails++;
    end
    bad = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 5; j++)
      if (d2[i][j] !== 32'(exp2[i][j])) begin
        if (bad == 0) $display("FAIL %s_d[%0d][%0d]: got %0d expected %0d", name, i, j, d2[i][j], exp2[i][j]);
        bad++;
      end
    tests++;
    if (bad != 0) fails++;
    release2();
  endtask

  task automatic test_reset_mid_mac();
    int bad, spurious;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) a2[i][k] = 16'(i * 3 + k - 2);
    for (int k = 0; k < 3; k++) for (int j = 0; j < 5; j++) b2[k][j] = 16'(k * 5 + j - 7);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 5; j++) c2[i][j] = 32'(100 * i + j);
    check_shape2("shape_first");
    @(negedge clk);
    op2 = 8'h01;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 5; j++) if (d2[i][j] !== 32'sd0) bad++;
    tests++;
    if (bad != 0 || out_valid2 !== 1'b0 || sat2 !== 1'b0 || err2 !== 1'b0 || in_ready2 !== 1'b1) begin
      $display("FAIL midmac_reset_outputs: got nonzero=%0d vld=%b sat=%b err=%b rdy=%b expected 0 0 0 0 1",
               bad, out_valid2, sat2, err2, in_ready2);
      fails++;
    end
    @(negedge clk);
    rst2_n = 1'b1;
    spurious = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) spurious++;
    end
    tests++;
    if (spurious != 0) begin
      $display("FAIL midmac_no_spurious: got %0d bad cycles expected 0", spurious);
      fails++;
    end
    check_shape2("shape_rerun");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_accumulate_off();
    test_saturation();
    test_unsigned();
    test_back_to_back();
    test_illegal_opcode();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
